// File: rtl/bomb_sched_pkg.sv
// Package: bomb_sched_pkg
// Shared types and constants for the bomb fuse scheduler.
//   slot_state_t : per-slot fuse lifecycle (FREE -> ARMED -> EXPIRED -> FREE)
//   out_state_t  : explosion port state (idle / holding a presented expiry)
//   DEFAULT_FUSE : 3 s fuse at the 64 Hz game tick
package bomb_sched_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    ARMED   = 2'd1,
    EXPIRED = 2'd2
  } slot_state_t;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_HOLD = 1'b1
  } out_state_t;

  localparam logic [7:0] DEFAULT_FUSE = 8'd192;

endpackage

// File: rtl/bomb_fuse_scheduler_rr_arbiter.sv
// Module: rr_arbiter
// Purely combinational round-robin pick. The search starts at ptr and wraps
// modulo N; the first requesting index wins.
// Ports:
//   req  in  N  request vector
//   ptr  in  W  search start index
//   gnt  out N  one-hot grant (all zero when no request)
//   idx  out W  index of the granted request
//   any  out 1  at least one request present
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    logic [W-1:0] j;
    j   = '0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = W'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/bomb_fuse_scheduler.sv
// Module: bomb_fuse_scheduler
// Shares the 64 Hz game tick among N_SLOTS bomb fuses. Armed slots count
// down on each slow_clk rise; expired slots are arbitrated round-robin onto
// one valid/ready explosion port.
// Ports:
//   Clk, Reset_n            system clock, async active-low reset
//   slow_clk                64 Hz square wave (rising edges only)
//   arm_valid/arm_ready     arm request handshake; ready = some slot FREE
//   arm_fuse, arm_tag       fuse length in ticks (0 acts as 1), payload
//   arm_slot                slot an accepted arm lands in (lowest FREE)
//   exp_valid/exp_ready     explosion handshake
//   exp_slot, exp_tag       presented expired slot and its payload
//   active                  bit i set while slot i is not FREE
// Build option: define FUSE_CHAIN_EN to add chain_valid/chain_slot, which
// force an ARMED slot to EXPIRED on the next cycle (chain reactions).
module bomb_fuse_scheduler
  import bomb_sched_pkg::*;
#(
  parameter  int N_SLOTS = 4,
  parameter  int FUSE_W  = 8,
  parameter  int TAG_W   = 8,
  localparam int SLOT_W  = $clog2(N_SLOTS)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                slow_clk,
  input  logic                arm_valid,
  output logic                arm_ready,
  input  logic [FUSE_W-1:0]   arm_fuse,
  input  logic [TAG_W-1:0]    arm_tag,
  output logic [SLOT_W-1:0]   arm_slot,
`ifdef FUSE_CHAIN_EN
  input  logic                chain_valid,
  input  logic [SLOT_W-1:0]   chain_slot,
`endif
  output logic                exp_valid,
  input  logic                exp_ready,
  output logic [SLOT_W-1:0]   exp_slot,
  output logic [TAG_W-1:0]    exp_tag,
  output logic [N_SLOTS-1:0]  active
);

  logic                 slow_d, tick;
  slot_state_t          st    [N_SLOTS];
  logic [FUSE_W-1:0]    cnt   [N_SLOTS];
  logic [TAG_W-1:0]     tag_q [N_SLOTS];
  logic [N_SLOTS-1:0]   free_v, exp_v, gnt;
  logic                 arm_fire, hs, any_exp;
  logic [FUSE_W-1:0]    fuse_eff;
  logic [SLOT_W-1:0]    win, ptr_q, ptr_nxt, slot_nxt;
  logic [TAG_W-1:0]     tag_nxt, sel_tag;
  out_state_t           out_st, out_nxt;

  // Delay flop resets high so slow_clk already high at reset release
  // does not look like a rising edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slow_d <= 1'b1;
      tick   <= 1'b0;
    end else begin
      slow_d <= slow_clk;
      tick   <= slow_clk & ~slow_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      free_v[i] = (st[i] == FREE);
      exp_v[i]  = (st[i] == EXPIRED);
    end
  end

  // Lowest FREE index: scan downward so the last hit is the lowest.
  always_comb begin
    arm_slot = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if (free_v[i]) arm_slot = SLOT_W'(i);
  end

  // arm_ready comes from registered state only; no path from exp_ready.
  assign arm_ready = |free_v;
  assign active    = ~free_v;
  assign arm_fire  = arm_valid & arm_ready;
  assign fuse_eff  = (arm_fuse == '0) ? FUSE_W'(1) : arm_fuse;
  assign exp_valid = (out_st == OUT_HOLD);
  assign hs        = exp_valid & exp_ready;

  // Slot array. A slot armed this cycle is FREE, so a coincident tick
  // cannot decrement it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        st[i]    <= FREE;
        cnt[i]   <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        case (st[i])
          FREE: begin
            if (arm_fire && arm_slot == SLOT_W'(i)) begin
              st[i]    <= ARMED;
              cnt[i]   <= fuse_eff;
              tag_q[i] <= arm_tag;
            end
          end
          ARMED: begin
`ifdef FUSE_CHAIN_EN
            if (chain_valid && chain_slot == SLOT_W'(i)) begin
              st[i]  <= EXPIRED;
              cnt[i] <= '0;
            end else
`endif
            if (tick) begin
              if (cnt[i] == FUSE_W'(1)) begin
                st[i]  <= EXPIRED;
                cnt[i] <= '0;
              end else if (cnt[i] != '0) begin
                cnt[i] <= cnt[i] - FUSE_W'(1);
              end
            end
          end
          EXPIRED: begin
            if (hs && exp_slot == SLOT_W'(i)) st[i] <= FREE;
          end
          default: st[i] <= FREE;
        endcase
      end
    end
  end

  rr_arbiter #(.N(N_SLOTS)) u_arb (
    .req (exp_v),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win),
    .any (any_exp)
  );

  always_comb begin
    sel_tag = '0;
    for (int i = 0; i < N_SLOTS; i++)
      if (gnt[i]) sel_tag |= tag_q[i];
  end

  // Output FSM: latch the winner in IDLE, hold it stable until accepted.
  always_comb begin
    out_nxt  = out_st;
    slot_nxt = exp_slot;
    tag_nxt  = exp_tag;
    ptr_nxt  = ptr_q;
    case (out_st)
      OUT_IDLE: begin
        if (any_exp) begin
          slot_nxt = win;
          tag_nxt  = sel_tag;
          out_nxt  = OUT_HOLD;
        end
      end
      OUT_HOLD: begin
        if (exp_ready) begin
          out_nxt = OUT_IDLE;
          ptr_nxt = (exp_slot == SLOT_W'(N_SLOTS - 1)) ? '0 : exp_slot + SLOT_W'(1);
        end
      end
      default: out_nxt = OUT_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_st   <= OUT_IDLE;
      exp_slot <= '0;
      exp_tag  <= '0;
      ptr_q    <= '0;
    end else begin
      out_st   <= out_nxt;
      exp_slot <= slot_nxt;
      exp_tag  <= tag_nxt;
      ptr_q    <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_bomb_fuse_scheduler.sv
// Directed bench for bomb_fuse_scheduler (N_SLOTS=4, FUSE_W=8, TAG_W=8).
// Inputs change and outputs are sampled on the falling edge of Clk.
module tb_bomb_fuse_scheduler;

  logic       Clk = 1'b0;
  logic       Reset_n, slow_clk;
  logic       arm_valid, arm_ready, exp_valid, exp_ready;
  logic [7:0] arm_fuse, arm_tag, exp_tag;
  logic [1:0] arm_slot, exp_slot;
  logic [3:0] active;
`ifdef FUSE_CHAIN_EN
  logic       chain_valid;
  logic [1:0] chain_slot;
`endif

  int tests  = 0;
  int failed = 0;

  bomb_fuse_scheduler #(.N_SLOTS(4), .FUSE_W(8), .TAG_W(8)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .slow_clk  (slow_clk),
    .arm_valid (arm_valid),
    .arm_ready (arm_ready),
    .arm_fuse  (arm_fuse),
    .arm_tag   (arm_tag),
    .arm_slot  (arm_slot),
`ifdef FUSE_CHAIN_EN
    .chain_valid (chain_valid),
    .chain_slot  (chain_slot),
`endif
    .exp_valid (exp_valid),
    .exp_ready (exp_ready),
    .exp_slot  (exp_slot),
    .exp_tag   (exp_tag),
    .active    (active)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One slow_clk rise; returns once the resulting tick has been applied.
  task automatic pulse();
    slow_clk = 1'b1; step(1);
    slow_clk = 1'b0; step(1);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; step(2);
    Reset_n = 1'b1; step(1);
  endtask

  task automatic arm(input logic [7:0] f, input logic [7:0] t, input int slot, input string tag);
    chk({tag, "_arm_ready"}, 32'(arm_ready), 1);
    chk({tag, "_arm_slot"}, 32'(arm_slot), slot);
    arm_valid = 1'b1; arm_fuse = f; arm_tag = t;
    step(1);
    arm_valid = 1'b0;
  endtask

  task automatic expect_exp(input int slot, input int t, input string tag);
    chk({tag, "_exp_valid"}, 32'(exp_valid), 1);
    chk({tag, "_exp_slot"}, 32'(exp_slot), slot);
    chk({tag, "_exp_tag"}, 32'(exp_tag), t);
  endtask

  task automatic accept();
    exp_ready = 1'b1; step(1);
    exp_ready = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; slow_clk = 1'b0; arm_valid = 1'b0; exp_ready = 1'b0;
    arm_fuse = '0; arm_tag = '0;
`ifdef FUSE_CHAIN_EN
    chain_valid = 1'b0; chain_slot = '0;
`endif
    step(2);
    // reset state
    chk("rst_active", 32'(active), 0);
    chk("rst_exp_valid", 32'(exp_valid), 0);
    chk("rst_exp_slot", 32'(exp_slot), 0);
    chk("rst_exp_tag", 32'(exp_tag), 0);
    chk("rst_arm_ready", 32'(arm_ready), 1);
    Reset_n = 1'b1; step(1);

    // 1: fuse 3, expiry after the third tick
    arm(8'd3, 8'h15, 0, "t1");
    chk("t1_active", 32'(active), 4'b0001);
    pulse(); chk("t1_tick1_no_exp", 32'(exp_valid), 0);
    pulse(); chk("t1_tick2_no_exp", 32'(exp_valid), 0);
    pulse(); chk("t1_tick3_no_exp_yet", 32'(exp_valid), 0);
    step(1);
    expect_exp(0, 8'h15, "t1");
    chk("t1_active_hold", 32'(active), 4'b0001);
    accept();
    chk("t1_exp_done", 32'(exp_valid), 0);
    chk("t1_active_free", 32'(active), 0);

    // 2: all slots busy, stalled arm gets the slot freed by handshake
    arm(8'd50, 8'hA0, 0, "t2s0");
    for (int k = 0; k < 10; k++) pulse();
    arm(8'd50, 8'hA1, 1, "t2s1");
    arm(8'd50, 8'hA2, 2, "t2s2");
    arm(8'd50, 8'hA3, 3, "t2s3");
    chk("t2_full_ready", 32'(arm_ready), 0);
    chk("t2_full_active", 32'(active), 4'b1111);
    arm_valid = 1'b1; arm_fuse = 8'd5; arm_tag = 8'hB5;
    for (int k = 0; k < 39; k++) pulse();
    chk("t2_stall_ready", 32'(arm_ready), 0);
    chk("t2_stall_no_exp", 32'(exp_valid), 0);
    pulse();
    step(1);
    expect_exp(0, 8'hA0, "t2");
    chk("t2_hold_ready", 32'(arm_ready), 0);
    exp_ready = 1'b1; step(1); exp_ready = 1'b0;
    chk("t2_freed_ready", 32'(arm_ready), 1);
    chk("t2_freed_slot", 32'(arm_slot), 0);
    step(1);
    arm_valid = 1'b0;
    chk("t2_rearmed_active", 32'(active), 4'b1111);
    chk("t2_rearmed_ready", 32'(arm_ready), 0);

    // 3: simultaneous expiries, held presentation, round robin
    do_reset();
    arm(8'd2, 8'hC0, 0, "t3s0");
    arm(8'd2, 8'hC1, 1, "t3s1");
    pulse(); pulse();
    step(1);
    expect_exp(0, 8'hC0, "t3a");
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("t3_hold_valid", 32'(exp_valid), 1);
      chk("t3_hold_slot", 32'(exp_slot), 0);
      chk("t3_hold_tag", 32'(exp_tag), 8'hC0);
    end
    accept();
    chk("t3_gap", 32'(exp_valid), 0);
    step(1);
    expect_exp(1, 8'hC1, "t3b");
    accept();
    chk("t3_all_free", 32'(active), 0);
    arm(8'd1, 8'hD0, 0, "t3d0");
    arm(8'd100, 8'hD1, 1, "t3d1");
    arm(8'd1, 8'hD2, 2, "t3d2");
    pulse();
    step(1);
    expect_exp(2, 8'hD2, "t3c");
    accept();
    chk("t3c_gap", 32'(exp_valid), 0);
    step(1);
    expect_exp(0, 8'hD0, "t3d");
    accept();
    chk("t3_left_active", 32'(active), 4'b0010);

    // 4: fuse 0 behaves as fuse 1
    do_reset();
    arm(8'd0, 8'hE0, 0, "t4s0");
    arm(8'd1, 8'hE1, 1, "t4s1");
    pulse();
    step(1);
    expect_exp(0, 8'hE0, "t4a");
    accept();
    step(1);
    expect_exp(1, 8'hE1, "t4b");
    accept();
    chk("t4_active", 32'(active), 0);

    // 5: reset mid-countdown with slow_clk held high
    do_reset();
    arm(8'd5, 8'hF5, 0, "t5s0");
    pulse(); pulse();
    slow_clk = 1'b1; Reset_n = 1'b0;
    step(1);
    chk("t5_rst_active", 32'(active), 0);
    chk("t5_rst_exp_valid", 32'(exp_valid), 0);
    step(2);
    Reset_n = 1'b1;
    arm(8'd1, 8'h51, 0, "t5re");
    step(5);
    chk("t5_no_spurious_exp", 32'(exp_valid), 0);
    chk("t5_still_armed", 32'(active), 4'b0001);
    slow_clk = 1'b0; step(1);
    chk("t5_low_no_exp", 32'(exp_valid), 0);
    pulse();
    step(1);
    expect_exp(0, 8'h51, "t5");
    accept();

`ifdef FUSE_CHAIN_EN
    // 6: chain detonation
    do_reset();
    arm(8'd200, 8'h60, 0, "t6s0");
    arm(8'd200, 8'h61, 1, "t6s1");
    arm(8'd200, 8'h62, 2, "t6s2");
    chain_valid = 1'b1; chain_slot = 2'd3; step(1); chain_valid = 1'b0;
    chk("t6_free_target_active", 32'(active), 4'b0111);
    step(1);
    chk("t6_free_target_no_exp", 32'(exp_valid), 0);
    chain_valid = 1'b1; chain_slot = 2'd2; step(1); chain_valid = 1'b0;
    chk("t6_chain_not_yet", 32'(exp_valid), 0);
    step(1);
    expect_exp(2, 8'h62, "t6");
    accept();
    chk("t6_active", 32'(active), 4'b0011);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
